i2c_bus_arbiter: RTL and testbench
==================================

I2C_BUS_ARBITER -- requirements
Module: i2c_bus_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of requester ports; legal values are 2 to 4.
REQ-002 Parameter WATCHDOG_CYCLES, default 270000 (10 ms at 27 MHz), SHALL set the maximum grant duration in clk cycles.
REQ-003 Clock clk, reset reset, synchronous, active-high.
REQ-004 Ports, in the form name direction width meaning:
- clk in 1: 27 MHz system clock.
- reset in 1: synchronous, active-high.
- req in NUM_REQ: per-requester bus request, level.
- req_done in NUM_REQ: per-requester transaction-complete pulse.
- grant out NUM_REQ: one-hot ownership flag.
- relinquish out NUM_REQ: one-cycle pulse that forces the owner to abort.
- r_cmd_start, r_cmd_read, r_cmd_write, r_cmd_stop, r_cmd_valid, r_data_out_valid, r_data_in_ready in NUM_REQ each: requester command bits.
- r_data_out in 8*NUM_REQ: requester write data, flattened.
- r_dev_address in 7*NUM_REQ: requester device address, flattened.
- m_cmd_start, m_cmd_read, m_cmd_write, m_cmd_stop, m_cmd_valid, m_data_out_valid, m_data_in_ready out 1 each: master command bits.
- m_data_out out 8: master write data.
- m_dev_address out 7: master device address.
- m_data_out_ready, m_data_in_valid, m_data_in_last, m_bus_busy, m_missed_ack in 1 each: master status.
- r_data_out_ready, r_data_in_valid, r_data_in_last, r_missed_ack out NUM_REQ each: master status routed to requesters.
- timeout_err out 1: one-cycle pulse on a watchdog abort.
- owner out 2: index of the current owner.
- state_out out 2: debug state.

Function
REQ-005 The FSM SHALL have exactly four states: IDLE=0, BUSY=1, RELEASE=2, COOLDOWN=3.
REQ-006 In IDLE with any req bit high, the FSM SHALL select an owner by round-robin starting at (last_owner+1) mod NUM_REQ, assert grant one cycle later, and enter BUSY (latency of 1 cycle from req to grant).
REQ-007 In IDLE with req all zero, the FSM SHALL remain in IDLE with grant held at 0.
REQ-008 Outside BUSY, all m_* command and data outputs SHALL be 0; no output of this block SHALL be driven to Z.
REQ-009 In BUSY, the m_* command and data outputs SHALL combinationally equal the owner's r_* bundle.
REQ-010 In BUSY, the r_data_out_ready, r_data_in_valid, r_data_in_last and r_missed_ack bits of the owner SHALL follow the master; all other requesters' bits SHALL be 0.
REQ-011 A 19-bit watchdog SHALL clear on entry to BUSY and increment on every BUSY cycle.
REQ-012 In BUSY, req_done[owner] high or req[owner] low SHALL cause the FSM to enter RELEASE on the next cycle.
REQ-013 In BUSY, watchdog equal to WATCHDOG_CYCLES-1 without a done SHALL pulse relinquish[owner] and timeout_err for 1 cycle and enter RELEASE.
REQ-014 When done and watchdog expiry occur in the same cycle, done SHALL win: no relinquish and no timeout_err.
REQ-015 req_done or req from a non-owner SHALL be ignored in all states.
REQ-016 In RELEASE, grant SHALL be 0 and last_owner SHALL update to owner; the FSM SHALL stay in RELEASE until m_bus_busy is 0, then enter COOLDOWN.
REQ-017 COOLDOWN SHALL last exactly 1 cycle and then enter IDLE, giving at least 2 idle-bus cycles between owners.
REQ-018 m_missed_ack SHALL NOT change the FSM state; it is only routed to the owner.
REQ-019 owner SHALL hold the last granted index outside BUSY.

Reset
REQ-020 Reset SHALL set: state to IDLE; grant, relinquish and timeout_err to 0; watchdog to 0; owner to 0; last_owner to NUM_REQ-1, so requester 0 has first priority.
REQ-021 Reset asserted in BUSY or RELEASE SHALL drop grant and all m_* outputs to 0 on the next edge, with no relinquish pulse.

Structure
REQ-022 Package i2c_arb_pkg SHALL hold the state encoding, the default WATCHDOG_CYCLES, and the per-requester field widths DATA_W=8 and ADDR_W=7.
REQ-023 Round-robin selection SHALL be a sub-module rr_pick with inputs req and last_owner and outputs valid and idx; the selection logic is purely combinational.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- req=0001 -> grant=0001 1 cycle later, BUSY; m_data_out follows r_data_out[7:0]=0x29.
- req=1111 held with done after each grant -> grant order 0,1,2,3,0, with a RELEASE+COOLDOWN gap of at least 2 cycles each time.
- Owner 2 never signals done, WATCHDOG_CYCLES=100 -> relinquish=0100 and timeout_err each pulse 1 cycle at BUSY cycle 100; the FSM enters RELEASE.
- done and watchdog expiry in the same cycle -> no relinquish, no timeout_err.
- m_bus_busy held high for 50 cycles after done -> the FSM stays in RELEASE for 50 cycles with grant=0, then COOLDOWN, then IDLE.
- reset mid-BUSY with req=0010 -> grant=0 and m_cmd_valid=0 next cycle; after reset, req=1010 -> requester 1 granted first.

Source files
------------

// File: rtl/i2c_arb_pkg.sv
// Shared encodings and widths for the I2C bus arbiter slice.
package i2c_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_BUSY     = 2'd1,
        ST_RELEASE  = 2'd2,
        ST_COOLDOWN = 2'd3
    } arb_state_t;

    localparam int unsigned WATCHDOG_CYCLES_DEF = 270000;
    localparam int unsigned DATA_W              = 8;
    localparam int unsigned ADDR_W              = 7;
    localparam int unsigned WD_W                = 19;
    localparam int unsigned IDX_W               = 2;
    localparam int unsigned MAX_REQ             = 4;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first active request after last_owner.
module rr_pick
    import i2c_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_owner,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    logic [MAX_REQ-1:0] req_p;
    logic [IDX_W-1:0]   cand;

    // Scan from the farthest candidate down so the nearest one wins.
    always_comb begin
        req_p = MAX_REQ'(req);
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = int'(NUM_REQ); i >= 1; i--) begin
            cand = IDX_W'((int'(last_owner) + i) % int'(NUM_REQ));
            if (req_p[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Shares one I2C master among up to four requesters with round-robin
// ownership, a grant watchdog and an enforced idle gap between owners.
module i2c_bus_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ         = 4,
    parameter int unsigned WATCHDOG_CYCLES = WATCHDOG_CYCLES_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_done,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        relinquish,
    input  logic [NUM_REQ-1:0]        r_cmd_start,
    input  logic [NUM_REQ-1:0]        r_cmd_read,
    input  logic [NUM_REQ-1:0]        r_cmd_write,
    input  logic [NUM_REQ-1:0]        r_cmd_stop,
    input  logic [NUM_REQ-1:0]        r_cmd_valid,
    input  logic [NUM_REQ-1:0]        r_data_out_valid,
    input  logic [NUM_REQ-1:0]        r_data_in_ready,
    input  logic [DATA_W*NUM_REQ-1:0] r_data_out,
    input  logic [ADDR_W*NUM_REQ-1:0] r_dev_address,
    output logic                      m_cmd_start,
    output logic                      m_cmd_read,
    output logic                      m_cmd_write,
    output logic                      m_cmd_stop,
    output logic                      m_cmd_valid,
    output logic                      m_data_out_valid,
    output logic                      m_data_in_ready,
    output logic [DATA_W-1:0]         m_data_out,
    output logic [ADDR_W-1:0]         m_dev_address,
    input  logic                      m_data_out_ready,
    input  logic                      m_data_in_valid,
    input  logic                      m_data_in_last,
    input  logic                      m_bus_busy,
    input  logic                      m_missed_ack,
    output logic [NUM_REQ-1:0]        r_data_out_ready,
    output logic [NUM_REQ-1:0]        r_data_in_valid,
    output logic [NUM_REQ-1:0]        r_data_in_last,
    output logic [NUM_REQ-1:0]        r_missed_ack,
    output logic                      timeout_err,
    output logic [IDX_W-1:0]          owner,
    output logic [1:0]                state_out
);

    arb_state_t         state;
    logic [IDX_W-1:0]   last_owner;
    logic [WD_W-1:0]    watchdog;
    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    logic [MAX_REQ-1:0] req_p;
    logic [MAX_REQ-1:0] done_p;
    logic               owner_done;
    logic               wd_expired;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
        .req        (req),
        .last_owner (last_owner),
        .valid      (pick_valid),
        .idx        (pick_idx)
    );

    // Dropping the request counts as done, so a requester can walk away cleanly.
    assign req_p      = MAX_REQ'(req);
    assign done_p     = MAX_REQ'(req_done);
    assign owner_done = done_p[owner] | ~req_p[owner];
    assign wd_expired = (watchdog == WD_W'(WATCHDOG_CYCLES - 1));
    assign state_out  = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            grant       <= '0;
            relinquish  <= '0;
            timeout_err <= 1'b0;
            watchdog    <= '0;
            owner       <= '0;
            last_owner  <= IDX_W'(NUM_REQ - 1);
        end else begin
            relinquish  <= '0;
            timeout_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        owner    <= pick_idx;
                        grant    <= NUM_REQ'(1) << pick_idx;
                        watchdog <= '0;
                        state    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    watchdog <= watchdog + WD_W'(1);
                    // A clean finish in the expiry cycle takes precedence over the abort.
                    if (owner_done) begin
                        grant <= '0;
                        state <= ST_RELEASE;
                    end else if (wd_expired) begin
                        grant       <= '0;
                        relinquish  <= NUM_REQ'(1) << owner;
                        timeout_err <= 1'b1;
                        state       <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    last_owner <= owner;
                    if (!m_bus_busy) begin
                        state <= ST_COOLDOWN;
                    end
                end
                ST_COOLDOWN: state <= ST_IDLE;
                default:     state <= ST_IDLE;
            endcase
        end
    end

    // Route the owner's bundle to the master and master status back to the owner only.
    always_comb begin
        m_cmd_start      = 1'b0;
        m_cmd_read       = 1'b0;
        m_cmd_write      = 1'b0;
        m_cmd_stop       = 1'b0;
        m_cmd_valid      = 1'b0;
        m_data_out_valid = 1'b0;
        m_data_in_ready  = 1'b0;
        m_data_out       = '0;
        m_dev_address    = '0;
        r_data_out_ready = '0;
        r_data_in_valid  = '0;
        r_data_in_last   = '0;
        r_missed_ack     = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (state == ST_BUSY && owner == IDX_W'(i)) begin
                m_cmd_start         = r_cmd_start[i];
                m_cmd_read          = r_cmd_read[i];
                m_cmd_write         = r_cmd_write[i];
                m_cmd_stop          = r_cmd_stop[i];
                m_cmd_valid         = r_cmd_valid[i];
                m_data_out_valid    = r_data_out_valid[i];
                m_data_in_ready     = r_data_in_ready[i];
                m_data_out          = r_data_out[i*DATA_W +: DATA_W];
                m_dev_address       = r_dev_address[i*ADDR_W +: ADDR_W];
                r_data_out_ready[i] = m_data_out_ready;
                r_data_in_valid[i]  = m_data_in_valid;
                r_data_in_last[i]   = m_data_in_last;
                r_missed_ack[i]     = m_missed_ack;
            end
        end
    end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Scoreboard bench for i2c_bus_arbiter: expected grants queued at stimulus,
// popped by a grant monitor; directed checks for watchdog, release and reset.
module tb_i2c_bus_arbiter;

    localparam int unsigned N = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] req, req_done, grant, relinquish;
    logic [N-1:0] r_cmd_start, r_cmd_read, r_cmd_write, r_cmd_stop, r_cmd_valid;
    logic [N-1:0] r_data_out_valid, r_data_in_ready;
    logic [31:0]  r_data_out;
    logic [27:0]  r_dev_address;
    logic         m_cmd_start, m_cmd_read, m_cmd_write, m_cmd_stop, m_cmd_valid;
    logic         m_data_out_valid, m_data_in_ready;
    logic [7:0]   m_data_out;
    logic [6:0]   m_dev_address;
    logic         m_data_out_ready, m_data_in_valid, m_data_in_last, m_bus_busy, m_missed_ack;
    logic [N-1:0] r_data_out_ready, r_data_in_valid, r_data_in_last, r_missed_ack;
    logic         timeout_err;
    logic [1:0]   owner, state_out;

    int n_tests = 0;
    int n_fail  = 0;
    logic [N-1:0] exp_q[$];

    always #5 clk = ~clk;

    i2c_bus_arbiter #(.NUM_REQ(N), .WATCHDOG_CYCLES(100)) dut (
        .clk(clk), .reset(reset), .req(req), .req_done(req_done),
        .grant(grant), .relinquish(relinquish),
        .r_cmd_start(r_cmd_start), .r_cmd_read(r_cmd_read), .r_cmd_write(r_cmd_write),
        .r_cmd_stop(r_cmd_stop), .r_cmd_valid(r_cmd_valid),
        .r_data_out_valid(r_data_out_valid), .r_data_in_ready(r_data_in_ready),
        .r_data_out(r_data_out), .r_dev_address(r_dev_address),
        .m_cmd_start(m_cmd_start), .m_cmd_read(m_cmd_read), .m_cmd_write(m_cmd_write),
        .m_cmd_stop(m_cmd_stop), .m_cmd_valid(m_cmd_valid),
        .m_data_out_valid(m_data_out_valid), .m_data_in_ready(m_data_in_ready),
        .m_data_out(m_data_out), .m_dev_address(m_dev_address),
        .m_data_out_ready(m_data_out_ready), .m_data_in_valid(m_data_in_valid),
        .m_data_in_last(m_data_in_last), .m_bus_busy(m_bus_busy), .m_missed_ack(m_missed_ack),
        .r_data_out_ready(r_data_out_ready), .r_data_in_valid(r_data_in_valid),
        .r_data_in_last(r_data_in_last), .r_missed_ack(r_missed_ack),
        .timeout_err(timeout_err), .owner(owner), .state_out(state_out)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_busy();
        int n = 0;
        while (state_out != 2'd1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (state_out != 2'd1) chk("wait_busy_timeout", 32'(state_out), 32'd1);
    endtask

    task automatic wait_grant();
        int n = 0;
        while (grant == '0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (grant == '0) chk("wait_grant_timeout", 32'(grant), 32'd1);
    endtask

    // Grant monitor: every new grant is popped against the scoreboard and gap-checked.
    logic [N-1:0] prev_grant = '0;
    logic         had_grant  = 1'b0;
    int           gap        = 0;
    always @(negedge clk) begin
        prev_grant <= grant;
        if (reset) begin
            had_grant <= 1'b0;
            gap       <= 0;
        end else if (grant == '0) begin
            gap <= gap + 1;
        end else if (prev_grant == '0) begin
            if (had_grant) chk("gap_min", 32'(gap >= 2), 32'd1);
            if (exp_q.size() == 0) chk("grant_unexpected", 32'(grant), 32'd0);
            else                   chk("grant_order", 32'(grant), 32'(exp_q.pop_front()));
            had_grant <= 1'b1;
            gap       <= 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int n, bad;
        reset = 1'b1;
        req = '0; req_done = '0;
        r_cmd_start = 4'b0101; r_cmd_read = 4'b0010; r_cmd_write = 4'b1001; r_cmd_stop = 4'b0100;
        r_cmd_valid = 4'b1111; r_data_out_valid = 4'b0011; r_data_in_ready = 4'b1100;
        r_data_out = 32'h4d3c_1a29;
        r_dev_address = {7'h0c, 7'h33, 7'h41, 7'h55};
        m_data_out_ready = 1'b0; m_data_in_valid = 1'b0; m_data_in_last = 1'b0;
        m_bus_busy = 1'b0; m_missed_ack = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_state", 32'(state_out), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_relinq", 32'(relinquish), 32'd0);
        chk("rst_timeout", 32'(timeout_err), 32'd0);
        chk("rst_mvalid", 32'(m_cmd_valid), 32'd0);
        chk("rst_mdata", 32'(m_data_out), 32'd0);
        reset = 1'b0;

        // Single requester: one-cycle latency and bundle routing.
        @(negedge clk);
        chk("idle_no_req", 32'(state_out), 32'd0);
        req = 4'b0001; exp_q.push_back(4'b0001);
        @(negedge clk);
        chk("grant_latency", 32'(grant), 32'h1);
        chk("busy_state", 32'(state_out), 32'd1);
        chk("m_data_out", 32'(m_data_out), 32'h29);
        chk("m_dev_addr", 32'(m_dev_address), 32'h55);
        chk("m_cmd_valid", 32'(m_cmd_valid), 32'd1);
        chk("m_cmd_start", 32'(m_cmd_start), 32'd1);
        m_data_out_ready = 1'b1; m_missed_ack = 1'b1;
        #1;
        chk("r_dout_ready", 32'(r_data_out_ready), 32'h1);
        chk("r_missed_ack", 32'(r_missed_ack), 32'h1);
        @(negedge clk);
        chk("missed_ack_no_fsm", 32'(state_out), 32'd1);
        m_data_out_ready = 1'b0; m_missed_ack = 1'b0;
        req_done = 4'b0001;
        @(negedge clk);
        req_done = '0; req = '0;
        chk("release_state", 32'(state_out), 32'd2);
        chk("release_grant", 32'(grant), 32'd0);
        chk("release_mvalid", 32'(m_cmd_valid), 32'd0);
        @(negedge clk);
        chk("cooldown_state", 32'(state_out), 32'd3);
        @(negedge clk);
        chk("back_idle", 32'(state_out), 32'd0);

        // All requesting from reset: order 0,1,2,3,0.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_q.push_back(4'b0001); exp_q.push_back(4'b0010); exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1000); exp_q.push_back(4'b0001);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_grant();
            req_done = grant;
            @(negedge clk);
            req_done = '0;
            if (k == 4) req = '0;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);

        // Watchdog abort for owner 2.
        req = 4'b0100; exp_q.push_back(4'b0100);
        wait_busy();
        n = 0;
        while (state_out == 2'd1 && n < 200) begin
            if (relinquish != '0 || timeout_err) n = n + 1000;
            n++;
            @(negedge clk);
        end
        chk("wd_busy_cycles", 32'(n), 32'd100);
        chk("wd_relinq", 32'(relinquish), 32'b0100);
        chk("wd_timeout", 32'(timeout_err), 32'd1);
        chk("wd_release", 32'(state_out), 32'd2);
        req = '0;
        @(negedge clk);
        chk("wd_pulse_len", 32'({relinquish, timeout_err}), 32'd0);
        repeat (3) @(negedge clk);

        // Done in the expiry cycle wins.
        req = 4'b0100; exp_q.push_back(4'b0100);
        wait_busy();
        repeat (99) @(negedge clk);
        req_done = 4'b0100;
        @(negedge clk);
        req_done = '0; req = '0;
        chk("tie_relinq", 32'(relinquish), 32'd0);
        chk("tie_timeout", 32'(timeout_err), 32'd0);
        chk("tie_release", 32'(state_out), 32'd2);
        repeat (3) @(negedge clk);

        // Bus stays busy 50 cycles after done.
        req = 4'b0001; exp_q.push_back(4'b0001);
        wait_busy();
        req_done = 4'b0001; m_bus_busy = 1'b1;
        @(negedge clk);
        req_done = '0; req = '0;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (state_out != 2'd2 || grant != '0) bad++;
            if (i == 49) m_bus_busy = 1'b0;
            @(negedge clk);
        end
        chk("busy_hold_release", 32'(bad), 32'd0);
        chk("busy_then_cooldown", 32'(state_out), 32'd3);
        @(negedge clk);
        chk("busy_then_idle", 32'(state_out), 32'd0);
        repeat (2) @(negedge clk);

        // Reset in BUSY, then requester 1 first.
        req = 4'b0010; exp_q.push_back(4'b0010);
        wait_busy();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_grant", 32'(grant), 32'd0);
        chk("midrst_mvalid", 32'(m_cmd_valid), 32'd0);
        chk("midrst_relinq", 32'(relinquish), 32'd0);
        chk("midrst_state", 32'(state_out), 32'd0);
        reset = 1'b0;
        req = 4'b1010; exp_q.push_back(4'b0010);
        @(negedge clk);
        chk("postrst_grant", 32'(grant), 32'b0010);
        chk("postrst_mdata", 32'(m_data_out), 32'h1a);
        chk("postrst_maddr", 32'(m_dev_address), 32'h41);
        req_done = 4'b0010;
        @(negedge clk);
        req_done = '0; req = '0;
        repeat (4) @(negedge clk);

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
